// File: rtl/note_sequencer.sv
// Song-table note sequencer: plays a 32-entry table of (note, duration) pairs as one-hot tone enables.
// Latency: start sampled at edge n -> FETCH at n+1 -> first note enable high from n+2.
// No backpressure: stop aborts playback on the next edge; start is ignored while busy.
module note_sequencer #(
  parameter int TICK_DIV = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [6:0] wr_data,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G,
  output logic       busy,
  output logic       done,
  output logic [4:0] note_idx
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [2:0] CODE_END = 3'd7;

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

  state_t        r_state;
  logic [6:0]    r_table [32];
  logic [4:0]    r_en;        // {G,F,E,D,C}
  logic          r_busy;
  logic          r_done;
  logic [4:0]    r_note_idx;
  logic [PW-1:0] r_presc;
  logic [4:0]    r_dur_cnt;

  logic [2:0]    w_code;
  logic [3:0]    w_dur;
  logic [4:0]    w_onehot;
  logic          w_tick;

  assign w_code = r_table[r_note_idx][6:4];
  assign w_dur  = r_table[r_note_idx][3:0];
  assign w_tick = (r_presc == PRESC_MAX);

  assign C        = r_en[0];
  assign D        = r_en[1];
  assign E        = r_en[2];
  assign F        = r_en[3];
  assign G        = r_en[4];
  assign busy     = r_busy;
  assign done     = r_done;
  assign note_idx = r_note_idx;

  // Decode the current entry's note code into tone enables; rests and the end marker give all-low.
  always_comb begin
    w_onehot = 5'b00000;
    case (w_code)
      3'd1:    w_onehot = 5'b00001;
      3'd2:    w_onehot = 5'b00010;
      3'd3:    w_onehot = 5'b00100;
      3'd4:    w_onehot = 5'b01000;
      3'd5:    w_onehot = 5'b10000;
      default: w_onehot = 5'b00000;
    endcase
  end

  // Song table: reset fills every entry with the end marker; writes land only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_table[i] <= 7'h70;
      end
    end else if (wr_en && (r_state == IDLE)) begin
      r_table[wr_addr] <= wr_data;
    end
  end

  // Playback FSM with registered enables, busy and done; stop overrides everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_en       <= 5'b00000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_note_idx <= 5'd0;
      r_presc    <= '0;
      r_dur_cnt  <= 5'd0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_state <= IDLE;
        r_en    <= 5'b00000;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state    <= FETCH;
              r_note_idx <= 5'd0;
              r_busy     <= 1'b1;
            end
          end
          FETCH: begin
            if (w_code == CODE_END) begin
              // Looping from entry 0 onto an end marker would spin forever, so that case ends instead.
              if (loop && (r_note_idx != 5'd0)) begin
                r_note_idx <= 5'd0;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_dur_cnt <= {1'b0, w_dur} + 5'd1;
              r_presc   <= '0;
              r_en      <= w_onehot;
              r_state   <= PLAY;
            end
          end
          PLAY: begin
            if (w_tick) begin
              r_presc   <= '0;
              r_dur_cnt <= r_dur_cnt - 5'd1;
              if (r_dur_cnt == 5'd1) begin
                r_en    <= 5'b00000;
                r_state <= GAP;
              end
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
          GAP: begin
            if (w_tick) begin
              r_presc    <= '0;
              r_note_idx <= r_note_idx + 5'd1;
              // Running off the end of the table acts as an end marker without fetching entry 0.
              if ((r_note_idx == 5'd31) && !loop) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= FETCH;
              end
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_en    <= 5'b00000;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter TICK_DIV SHALL default to 2500000 and set the clk cycles per duration tick (25 ms at 100 MHz); its legal range SHALL be >= 2.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 start  in  1  single-cycle pulse to begin playback at entry 0; ignored while busy.
REQ-006 stop  in  1  level, aborts playback; has priority over start.
REQ-007 loop  in  1  sampled at each end marker; 1 restarts playback at entry 0.
REQ-008 wr_en, wr_addr[4:0], wr_data[6:0]  in  song table write port; wr_data[6:4] is the note code and wr_data[3:0] is the duration.
REQ-009 C, D, E, F, G  out  1 each  registered note enables, at most one high; these feed the downstream tone generators.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse on natural song completion.
REQ-012 note_idx  out  5  table address currently being played.

Function
REQ-013 Song table SHALL be 32 x 7-bit registers; note codes: 0=rest, 1=C, 2=D, 3=E, 4=F, 5=G, 6=rest, 7=end marker.
REQ-014 A write SHALL take effect on the clk edge with wr_en=1 only when state=IDLE; writes while busy SHALL be dropped.
REQ-015 FSM states SHALL be IDLE, FETCH, PLAY, GAP.
REQ-016 IDLE with start=1 and stop=0 SHALL go to FETCH with note_idx=0.
REQ-017 FETCH (exactly one cycle), non-end code: load dur_cnt = duration+1 ticks, clear the prescaler, go to PLAY.
REQ-018 FETCH, end code, loop=1 and note_idx!=0: set note_idx=0 and stay in FETCH.
REQ-019 FETCH, end code, otherwise: go to IDLE and assert done for that next cycle.
REQ-020 PLAY SHALL drive the one-hot enable for the note code (all low for a rest) for (duration+1)*TICK_DIV cycles, then go to GAP.
REQ-021 GAP SHALL drive all enables low for TICK_DIV cycles, then increment note_idx and go to FETCH.
REQ-022 When note_idx=31 and GAP completes, note_idx SHALL wrap to 0 and the wrap SHALL be treated as an end marker: apply REQ-018/019 directly, without a FETCH of entry 0.
REQ-023 The prescaler SHALL count 0..TICK_DIV-1 and clear on every entry to PLAY or GAP.
REQ-024 dur_cnt SHALL be 5 bits, so duration 15 gives 16 ticks without overflow.
REQ-025 stop=1 in any state SHALL force IDLE on the next edge, with all enables low, done=0, and note_idx held.
REQ-026 Enables, busy and done SHALL be registered with no combinational path from any input.
REQ-027 Latency: start at edge n SHALL give FETCH at n+1 and a note enable high from n+2.

Reset
REQ-028 On reset: state=IDLE, C..G=0, busy=0, done=0, note_idx=0, prescaler=0, dur_cnt=0.
REQ-029 On reset, every table entry SHALL be set to 7'h70 (end marker).
REQ-030 Reset asserted mid-note SHALL silence all enables immediately (asynchronously) and hold them silent until reset is released.

Verification (TICK_DIV=4)
REQ-031 Entry0=7'h11 (C, dur 1), entry1=7'h70, start at cycle 0 -> C high cycles 2-9, all low 10-13, FETCH 14, done=1 and busy=0 at cycle 15.
REQ-032 Same table with loop=1 -> C re-asserts at cycle 16 and done never pulses; stop at cycle 20 -> C low and busy=0 at cycle 21.
REQ-033 Table left at reset contents, loop=1, start -> done pulse at cycle 2 with no hang (REQ-018 guard).
REQ-034 All 32 entries =7'h50 (G, dur 0), loop=0 -> 32 G pulses of 4 cycles each, then wrap, done, note_idx=0.
REQ-035 wr_en while busy is dropped, and start pulses while busy are ignored (playback unchanged); async reset mid-PLAY -> all outputs 0 within the same cycle.
